mfr_sequencer: RTL and testbench

- Command-side driver for a 4-bit multifunction register.
- Accepts an operand plus a short function program from an upstream producer over a dav_/rfd handshake.
- Drives the register's function-select and operand inputs step by step, then captures the register output.
- Delivers the captured result to a downstream consumer over a second dav_/rfd handshake.

---
 rtl/mfr_sequencer.sv | 130 +++++++++++++
 tb/tb_mfr_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mfr_sequencer.sv
// Command-side sequencer for a 4-bit multifunction register: takes an
// operand and a function program from upstream, steps the register through
// it, captures the result and hands it downstream.
//
// Ports:
//   clock, reset_        system clock, async active-low reset
//   dav_in_, rfd_in      upstream handshake (valid active low, ready)
//   x_in, prog_in,       operand, four 2-bit function codes, step count-1
//   len_in
//   b_out, x_out         function select and operand to the register
//   z_in                 register output
//   z_out                captured result
//   dav_out_, rfd_out    downstream handshake (valid active low, ready)
module mfr_sequencer #(
    parameter int K         = 4,
    parameter int HOLD_CODE = 3,
    localparam int SW       = $clog2(K) + 1
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          dav_in_,
    output logic          rfd_in,
    input  logic [3:0]    x_in,
    input  logic [7:0]    prog_in,
    input  logic [1:0]    len_in,
    output logic [SW-1:0] b_out,
    output logic [3:0]    x_out,
    input  logic [3:0]    z_in,
    output logic [3:0]    z_out,
    output logic          dav_out_,
    input  logic          rfd_out
);

    typedef enum logic [2:0] {
        WAIT_IN,
        ACK_IN,
        RUN,
        SETTLE,
        CAPTURE,
        WAIT_RFD,
        ACK_OUT
    } state_t;

    localparam logic [SW-1:0] HOLD_SEL = SW'(HOLD_CODE);

    state_t     r_state;
    logic [1:0] r_step;
    logic [3:0] r_x;
    logic [7:0] r_prog;
    logic [1:0] r_len;

    logic [1:0] w_step_nxt;
    logic [1:0] w_code_nxt;
    logic [1:0] w_code_first;

    assign w_step_nxt   = r_step + 2'd1;
    // Code for the step after the current one, so b_out is already correct
    // during the cycle that step executes.
    assign w_code_nxt   = r_prog[{w_step_nxt, 1'b0} +: 2];
    assign w_code_first = r_prog[1:0];

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state  <= WAIT_IN;
            r_step   <= 2'd0;
            r_x      <= 4'd0;
            r_prog   <= 8'd0;
            r_len    <= 2'd0;
            rfd_in   <= 1'b1;
            dav_out_ <= 1'b1;
            z_out    <= 4'd0;
            x_out    <= 4'd0;
            b_out    <= HOLD_SEL;
        end else begin
            unique case (r_state)
                WAIT_IN: begin
                    b_out <= HOLD_SEL;
                    if (!dav_in_) begin
                        r_x     <= x_in;
                        r_prog  <= prog_in;
                        r_len   <= len_in;
                        rfd_in  <= 1'b0;
                        r_state <= ACK_IN;
                    end
                end
                ACK_IN: begin
                    if (dav_in_) begin
                        r_step  <= 2'd0;
                        b_out   <= SW'(w_code_first);
                        x_out   <= r_x;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (r_step == r_len) begin
                        b_out   <= HOLD_SEL;
                        r_state <= SETTLE;
                    end else begin
                        r_step <= w_step_nxt;
                        b_out  <= SW'(w_code_nxt);
                    end
                end
                SETTLE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    z_out   <= z_in;
                    r_state <= WAIT_RFD;
                end
                WAIT_RFD: begin
                    if (rfd_out) begin
                        dav_out_ <= 1'b0;
                        r_state  <= ACK_OUT;
                    end
                end
                ACK_OUT: begin
                    if (!rfd_out) begin
                        dav_out_ <= 1'b1;
                        rfd_in   <= 1'b1;
                        r_state  <= WAIT_IN;
                    end
                end
                default: begin
                    r_state <= WAIT_IN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfr_sequencer.sv
// Bench for mfr_sequencer: register model, directed transactions and a
// scoreboard popped by a monitor on each delivered result.
module tb_mfr_sequencer;

    logic       clock;
    logic       reset_;
    logic       dav_in_;
    logic       rfd_in;
    logic [3:0] x_in;
    logic [7:0] prog_in;
    logic [1:0] len_in;
    logic [2:0] b_out;
    logic [3:0] x_out;
    logic [3:0] z_in;
    logic [3:0] z_out;
    logic       dav_out_;
    logic       rfd_out;

    int n_vec;
    int n_bad;
    logic [3:0] exp_q[$];
    logic [3:0] outr;
    logic       prev_dav;

    mfr_sequencer dut (
        .clock    (clock),
        .reset_   (reset_),
        .dav_in_  (dav_in_),
        .rfd_in   (rfd_in),
        .x_in     (x_in),
        .prog_in  (prog_in),
        .len_in   (len_in),
        .b_out    (b_out),
        .x_out    (x_out),
        .z_in     (z_in),
        .z_out    (z_out),
        .dav_out_ (dav_out_),
        .rfd_out  (rfd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register model: f0 load, f1 add, f2 shift left, f3 hold.
    initial outr = 4'd0;
    always @(posedge clock) begin
        case (b_out)
            3'd0:    outr <= x_out;
            3'd1:    outr <= outr + x_out;
            3'd2:    outr <= outr << 1;
            default: outr <= outr;
        endcase
    end
    assign z_in = outr;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every falling dav_out_ delivers one scoreboard entry.
    initial prev_dav = 1'b1;
    always @(negedge clock) begin
        if (prev_dav && !dav_out_) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("scoreboard_z", z_out, exp_q.pop_front());
            end
        end
        prev_dav = dav_out_;
    end

    task automatic send_in(input logic [3:0] x, input logic [7:0] p,
                           input logic [1:0] l);
        int k;
        k = 0;
        while (!rfd_in && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("rfd_in_ready", rfd_in, 1);
        x_in    = x;
        prog_in = p;
        len_in  = l;
        dav_in_ = 1'b0;
        @(negedge clock);
        chk("rfd_in_drop", rfd_in, 0);
        chk("b_hold_ack", b_out, 3);
        dav_in_ = 1'b1;
        x_in    = 4'hF;
        prog_in = 8'hFF;
        @(negedge clock);
    endtask

    task automatic run_txn(input logic [3:0] x, input logic [7:0] p,
                           input logic [1:0] l, input logic [3:0] z,
                           input int hold);
        int k;
        rfd_out = 1'b0;
        send_in(x, p, l);
        exp_q.push_back(z);
        for (int i = 0; i <= int'(l); i++) begin
            chk("b_step", b_out, int'(p[2*i +: 2]));
            chk("x_step", x_out, x);
            @(negedge clock);
        end
        chk("b_settle", b_out, 3);
        @(negedge clock);
        @(negedge clock);
        chk("z_latency", z_out, z);
        for (int i = 0; i < hold; i++) begin
            chk("dav_wait", dav_out_, 1);
            chk("rfd_in_wait", rfd_in, 0);
            chk("z_stable", z_out, z);
            chk("b_idle", b_out, 3);
            @(negedge clock);
        end
        rfd_out = 1'b1;
        k = 0;
        @(negedge clock);
        while (dav_out_ && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("dav_fall", dav_out_, 0);
        chk("rfd_in_ack", rfd_in, 0);
        rfd_out = 1'b0;
        @(negedge clock);
        chk("dav_rise", dav_out_, 1);
        chk("rfd_in_back", rfd_in, 1);
        chk("z_held", z_out, z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        reset_  = 1'b0;
        dav_in_ = 1'b1;
        rfd_out = 1'b0;
        x_in    = 4'd0;
        prog_in = 8'd0;
        len_in  = 2'd0;
        @(negedge clock);
        @(negedge clock);
        reset_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("rst_rfd_in", rfd_in, 1);
            chk("rst_dav_out", dav_out_, 1);
            chk("rst_z_out", z_out, 0);
            chk("rst_b_out", b_out, 3);
        end

        run_txn(4'd5, 8'b00_00_01_00, 2'd1, 4'hA, 2);
        run_txn(4'd3, 8'b10_10_01_00, 2'd3, 4'h8, 2);
        run_txn(4'd9, 8'b00_00_00_11, 2'd0, 4'h8, 2);
        run_txn(4'd2, 8'b00_00_01_00, 2'd1, 4'h4, 10);

        // Reset during RUN step 1.
        rfd_out = 1'b0;
        send_in(4'd6, 8'b00_10_01_00, 2'd2);
        chk("abort_b0", b_out, 0);
        @(negedge clock);
        chk("abort_b1", b_out, 1);
        reset_ = 1'b0;
        #1;
        chk("async_rfd_in", rfd_in, 1);
        chk("async_dav_out", dav_out_, 1);
        chk("async_z_out", z_out, 0);
        chk("async_x_out", x_out, 0);
        chk("async_b_out", b_out, 3);
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        chk("post_rst_dav", dav_out_, 1);
        chk("post_rst_z", z_out, 0);
        run_txn(4'd7, 8'b00_00_10_00, 2'd1, 4'hE, 2);

        repeat (3) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
